// File: rtl/jt12_kon_sched.sv
// Key-on write scheduler: queues register 0x28 writes, merges repeated writes to
// a channel, and hands them one at a time to the key-on shift-register block.
module jt12_kon_sched #(
    parameter int DEPTH = 4,
    parameter int TMO   = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       wr,
    input  logic [7:0] din,
    input  logic [1:0] next_op,
    input  logic [2:0] next_ch,
    output logic [3:0] keyon_op,
    output logic [2:0] keyon_ch,
    output logic       up_keyon,
    output logic       busy,
    output logic [3:0] level,
    output logic       ovf,
    output logic       tmo_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = $clog2(TMO + 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TMO - 1);
    localparam logic [3:0]    LVL_FULL = 4'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state;

    logic [3:0]    q_op [DEPTH];
    logic [2:0]    q_ch [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, hit_idx, w_idx;
    logic [WW-1:0] wd;
    logic          wr_ok, hit, pop, do_coal, do_app, do_drop;
    logic [3:0]    head_op;

    // NOTE: every signal gets a default before the search loop, so no latch is inferred.
    always_comb begin
        wr_ok   = wr && (din[1:0] != 2'b11);
        pop     = (state == IDLE) && (level != 4'd0);
        hit     = 1'b0;
        hit_idx = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            if ((4'(k) < level) && (q_ch[rd_ptr + PW'(k)] == din[2:0])) begin
                hit     = 1'b1;
                hit_idx = rd_ptr + PW'(k);
            end
        end
        do_coal = wr_ok && hit;
        // A pop on the same cycle frees a slot for the incoming write.
        do_app  = wr_ok && !hit && ((level != LVL_FULL) || pop);
        do_drop = wr_ok && !hit && (level == LVL_FULL) && !pop;
        w_idx   = do_coal ? hit_idx : wr_ptr;
        head_op = (do_coal && (hit_idx == rd_ptr)) ? din[7:4] : q_op[rd_ptr];
    end

    assign busy = (state != IDLE) || (level != 4'd0);

    // NOTE: queue storage is not reset; level alone says which entries are live.
    always_ff @(posedge clk) begin
        if (clk_en && (do_coal || do_app)) begin
            q_op[w_idx] <= din[7:4];
            q_ch[w_idx] <= din[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (rst) begin
                state    <= IDLE;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                level    <= 4'd0;
                wd       <= '0;
                keyon_op <= 4'd0;
                keyon_ch <= 3'd0;
                up_keyon <= 1'b0;
                ovf      <= 1'b0;
                tmo_err  <= 1'b0;
            end else begin
                if (do_drop) ovf <= 1'b1;
                if (do_app)  wr_ptr <= wr_ptr + PW'(1);
                if (pop)     rd_ptr <= rd_ptr + PW'(1);
                level <= level + {3'b000, do_app} - {3'b000, pop};

                case (state)
                    IDLE: begin
                        if (pop) begin
                            keyon_op <= head_op;
                            keyon_ch <= q_ch[rd_ptr];
                            up_keyon <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        up_keyon <= 1'b0;
                        wd       <= '0;
                        state    <= WAIT;
                    end
                    WAIT: begin
                        wd <= wd + WW'(1);
                        // The op-3 slot of the issued channel is where downstream latches it.
                        if ((next_op == 2'd3) && (next_ch == keyon_ch)) begin
                            state <= IDLE;
                        end else if (wd == WD_LAST) begin
                            tmo_err <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jt12_kon_sched.sv
// Randomised and directed bench for jt12_kon_sched: a transaction-level model predicts
// each issue and a monitor compares every up_keyon pulse against that scoreboard.
module tb_jt12_kon_sched;
    localparam int DEPTH = 4;
    localparam int TMO   = 31;

    logic       clk = 1'b0;
    logic       rst, clk_en, wr;
    logic [7:0] din;
    logic [1:0] next_op;
    logic [2:0] next_ch;
    logic [3:0] keyon_op;
    logic [2:0] keyon_ch;
    logic       up_keyon, busy, ovf, tmo_err;
    logic [3:0] level;

    jt12_kon_sched #(.DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .wr(wr), .din(din),
        .next_op(next_op), .next_ch(next_ch), .keyon_op(keyon_op),
        .keyon_ch(keyon_ch), .up_keyon(up_keyon), .busy(busy),
        .level(level), .ovf(ovf), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] ch;
    } ent_t;

    ent_t pend[$];
    ent_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: an issued update occupies the key-on block for one gap cycle, then is
    // watched for its latch slot for at most TMO cycles.
    bit   m_active = 1'b0;
    bit   m_gap    = 1'b0;
    bit   m_ovf    = 1'b0;
    bit   m_tmo    = 1'b0;
    int   m_watch  = 0;
    ent_t m_cur    = '0;

    int   slot     = 0;
    bit   slot_run = 1'b1;
    bit   prev_up  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] slot_ch(input int s);
        int c;
        c = s % 6;
        return (c < 3) ? 3'(c) : 3'(c + 1);
    endfunction

    function automatic logic [1:0] slot_op(input int s);
        return 2'(s / 6);
    endfunction

    task automatic model(input bit en, input bit r, input bit w, input logic [7:0] d,
                         input logic [1:0] op, input logic [2:0] ch);
        bit   take;
        int   idx;
        ent_t e;
        if (!en) return;
        if (r) begin
            pend.delete();
            m_active = 1'b0;
            m_gap    = 1'b0;
            m_watch  = 0;
            m_ovf    = 1'b0;
            m_tmo    = 1'b0;
            m_cur    = '0;
            return;
        end
        take = !m_active && (pend.size() > 0);
        if (m_active) begin
            if (m_gap) begin
                m_gap   = 1'b0;
                m_watch = 0;
            end else begin
                m_watch++;
                if (op == 2'd3 && ch == m_cur.ch) m_active = 1'b0;
                else if (m_watch == TMO) begin
                    m_active = 1'b0;
                    m_tmo    = 1'b1;
                end
            end
        end
        if (w && d[1:0] != 2'b11) begin
            idx = -1;
            foreach (pend[i]) if (pend[i].ch == d[2:0]) idx = i;
            if (idx >= 0) pend[idx].op = d[7:4];
            else if (pend.size() - int'(take) < DEPTH) begin
                e.op = d[7:4];
                e.ch = d[2:0];
                pend.push_back(e);
            end else m_ovf = 1'b1;
        end
        if (take) begin
            m_cur = pend.pop_front();
            exp_q.push_back(m_cur);
            m_active = 1'b1;
            m_gap    = 1'b1;
        end
    endtask

    task automatic tick(input bit en, input bit w, input logic [7:0] d, input bit r);
        logic [1:0] op;
        logic [2:0] ch;
        op = slot_run ? slot_op(slot) : 2'd0;
        ch = slot_ch(slot);
        clk_en = en; wr = w; din = d; rst = r; next_op = op; next_ch = ch;
        model(en, r, w, d, op, ch);
        if (en && slot_run) slot = (slot + 1) % 24;
        @(posedge clk);
        #1;
        check("level",    32'(level),    32'(pend.size()));
        check("busy",     32'(busy),     32'(m_active || pend.size() > 0));
        check("ovf",      32'(ovf),      32'(m_ovf));
        check("tmo_err",  32'(tmo_err),  32'(m_tmo));
        check("keyon_op", 32'(keyon_op), 32'(m_cur.op));
        check("keyon_ch", 32'(keyon_ch), 32'(m_cur.ch));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    // Each clk_en cycle is seen exactly once, on the negedge where clk_en is high.
    always @(negedge clk) begin
        if (clk_en === 1'b1) begin
            if (prev_up) check("up_keyon width", 32'(up_keyon), 32'd0);
            else if (up_keyon === 1'b1) begin
                if (exp_q.size() == 0) check("spurious up_keyon", 32'(up_keyon), 32'd0);
                else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    check("issue op", 32'(keyon_op), 32'(e.op));
                    check("issue ch", 32'(keyon_ch), 32'(e.ch));
                end
            end
            prev_up = (up_keyon === 1'b1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL sim timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        check("reset up_keyon", 32'(up_keyon), 32'd0);
        check("reset level", 32'(level), 32'd0);

        // Single write and its latency.
        tick(1'b1, 1'b1, 8'hF1, 1'b0);
        check("latency early", 32'(up_keyon), 32'd0);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        check("latency pulse", 32'(up_keyon), 32'd1);
        check("single op", 32'(keyon_op), 32'hF);
        check("single ch", 32'(keyon_ch), 32'd1);
        run(40);
        check("single idle", 32'(busy), 32'd0);

        // Coalesce while channel 5 waits.
        slot_run = 1'b0;
        tick(1'b1, 1'b1, 8'h35, 1'b0);
        run(2);
        tick(1'b1, 1'b1, 8'h12, 1'b0);
        tick(1'b1, 1'b1, 8'h52, 1'b0);
        check("coalesce level", 32'(level), 32'd1);
        slot_run = 1'b1;
        run(60);

        // Overflow while channel 5 waits.
        slot_run = 1'b0;
        tick(1'b1, 1'b1, 8'hA5, 1'b0);
        run(2);
        tick(1'b1, 1'b1, 8'h10, 1'b0);
        tick(1'b1, 1'b1, 8'h21, 1'b0);
        tick(1'b1, 1'b1, 8'h32, 1'b0);
        tick(1'b1, 1'b1, 8'h44, 1'b0);
        tick(1'b1, 1'b1, 8'h66, 1'b0);
        check("overflow flag", 32'(ovf), 32'd1);
        check("overflow level", 32'(level), 32'd4);
        slot_run = 1'b1;
        run(200);

        // Invalid codes and gated writes.
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        tick(1'b1, 1'b1, 8'hF3, 1'b0);
        tick(1'b1, 1'b1, 8'hF7, 1'b0);
        tick(1'b0, 1'b1, 8'hF1, 1'b0);
        run(5);
        check("invalid level", 32'(level), 32'd0);
        check("invalid ovf", 32'(ovf), 32'd0);

        // Watchdog: latch slot never arrives.
        slot_run = 1'b0;
        tick(1'b1, 1'b1, 8'hF0, 1'b0);
        tick(1'b1, 1'b1, 8'h31, 1'b0);
        run(75);
        check("watchdog flag", 32'(tmo_err), 32'd1);
        slot_run = 1'b1;
        run(10);

        // Reset in WAIT with three entries queued.
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        slot_run = 1'b0;
        tick(1'b1, 1'b1, 8'h90, 1'b0);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b1, 1'b1, 8'h11, 1'b0);
        tick(1'b1, 1'b1, 8'h22, 1'b0);
        tick(1'b1, 1'b1, 8'h34, 1'b0);
        check("pre-reset level", 32'(level), 32'd3);
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        check("mid reset level", 32'(level), 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset up_keyon", 32'(up_keyon), 32'd0);
        slot_run = 1'b1;
        run(30);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(199) == 0) slot_run = !slot_run;
            tick($urandom_range(4) != 0, $urandom_range(5) == 0, 8'($urandom),
                 $urandom_range(399) == 0);
        end
        slot_run = 1'b1;
        run(200);
        check("missing issues", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jt12_kon_sched.md
Name: jt12_kon_sched

Overview:
- Key-on write scheduler between the CPU register interface (register 0x28 writes) and the key-on shift-register block.
- The key-on block holds only one pending key-on update. It needs a full operator/channel slot rotation to latch that update.
- This block queues key-on writes, coalesces repeated writes to the same channel, and issues them one at a time. Each issue uses a single up_keyon pulse, sent only after the previous update has been consumed at its channel's op-3 slot.
- All state advances only on clk_en.

Parameters:
- DEPTH, 4, queue entries (power of two, 2..8).
- TMO, 31, watchdog limit in clk_en cycles for the WAIT state.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high. Sampled only on clk edges, and only when clk_en=1.
- clk_en  in  1  clock enable. No state changes when low.
- wr  in  1  key-on register write strobe, one clk_en cycle.
- din  in  8  write data: [7:4] operator mask (S4,S3,S2,S1 order as consumed downstream); [2:0] channel code.
- next_op  in  2  operator of the slot being processed.
- next_ch  in  3  channel of the slot being processed.
- keyon_op  out  4  operator mask of the issued update.
- keyon_ch  out  3  channel code of the issued update.
- up_keyon  out  1  one-cycle issue strobe.
- busy  out  1  high when the FSM is not IDLE or the queue is non-empty.
- level  out  4  number of queued, unissued entries (0..DEPTH).
- ovf  out  1  sticky: a write was dropped because the queue was full.
- tmo_err  out  1  sticky: the watchdog expired in WAIT.

Behaviour:
- Reset values: up_keyon=0, keyon_op=0, keyon_ch=0, ovf=0, tmo_err=0, level=0, FSM=IDLE, queue empty, watchdog=0.
- Channel codes with din[1:0]==2'b11 are invalid. Such writes are ignored entirely: no enqueue, no flag.

Enqueue (on a clk_en cycle with wr=1 and a valid code):
- Coalesce: if an unissued queued entry has the same channel code, overwrite its op mask with din[7:4]. Its queue position is kept; level is unchanged.
- Else, if level<DEPTH: append a new entry at the tail; level+1.
- Else: drop the write and set ovf=1.
- An entry already issued (the FSM's current entry) never coalesces. A same-channel write while in WAIT enqueues as a new entry.

FSM, three states:
- IDLE: if level>0, pop the head and register keyon_op/keyon_ch from it. Drive up_keyon=1 for that one clk_en cycle, then go to ISSUE.
- ISSUE: up_keyon=0. Clear the watchdog. Go to WAIT.
- WAIT: exit on a clk_en cycle where next_ch==keyon_ch and next_op==2'd3 (the downstream latch slot). Go to IDLE on the following edge.
  - The watchdog increments each clk_en cycle in WAIT.
  - On reaching TMO: set tmo_err=1 and go to IDLE.

Timing:
- keyon_op/keyon_ch are stable from the up_keyon cycle until the next issue.
- Minimum spacing between up_keyon pulses is 3 clk_en cycles. Worst case is 26 with a full 24-slot rotation.
- Latency: write accepted at edge t with the queue empty and FSM IDLE → up_keyon high in the clk_en cycle after t+1.

Simultaneous events:
- A write and a pop in the same cycle with level==DEPTH: the pop frees a slot first, so the write is accepted (not dropped).
- A write that coalesces into the head entry on the same cycle the head is popped: the new mask goes to the issued entry. The issued keyon_op reflects din[7:4].
- wr with clk_en=0 is ignored.

Reset mid-operation:
- All queued entries are discarded and the FSM returns to IDLE.
- up_keyon is forced low on the reset edge even if it is mid-pulse.
- Sticky flags clear only on reset.

level arithmetic: exact count, no wrap. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.

Test Plan:
- Single write: din=8'hF1, queue empty, slot counter cycling. Required response:
  - up_keyon pulses once, 1 clk_en wide, with keyon_op=4'hF and keyon_ch=3'd1.
  - WAIT exits one cycle after next_ch=1 with next_op=3.
  - busy then drops.
- Coalesce: write din=8'h12 while another channel is in WAIT, then din=8'h52 before issue. Required response: level stays 1, and the issue carries keyon_op=4'h5, keyon_ch=3'd2.
- Overflow: DEPTH=4; write channels 0,1,2,4 while in WAIT on channel 5, then a write to channel 6. Required response:
  - ovf=1 and level=4.
  - The five issues occur in order 5,0,1,2,4.
  - No issue occurs for channel 6.
- Invalid code: din=8'hF3 and din=8'hF7. Required response: level unchanged, no up_keyon, ovf stays 0.
- Watchdog: next_op held at 0 after an issue. Required response: tmo_err=1 after TMO clk_en cycles in WAIT, FSM returns to IDLE, and the next queued entry issues.
- Reset mid-WAIT with level=3. Required response: after the reset edge, level=0, busy=0, up_keyon=0, ovf=0, tmo_err=0, and no further issues without new writes.
